// File: rtl/fifo_tx_drain.sv
`default_nettype none
// ============================================================================
// Module  : fifo_tx_drain
// Brief   : Pops words from a FIFO read port and sends each one as an
//           asynchronous serial frame (start, data LSB first, parity, stop).
// Revision: 1.0  initial release
// ============================================================================
module fifo_tx_drain #(
  parameter int DATO_WIDTH   = 3,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATO_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic [7:0]            frame_cnt
);

  localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_MAX = (DATO_WIDTH > STOP_BITS) ? DATO_WIDTH : STOP_BITS;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  C_DATA_LAST = BIT_W'(DATO_WIDTH - 1);
  localparam logic [BIT_W-1:0]  C_STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam bit                C_PAR_EN    = (PARITY != 0);
  localparam bit                C_PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATO_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    rd_q, rd_d;
  logic                    busy_q, busy_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    baud_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are registered: tx_d carries the line level of the next state.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    rd_d     = 1'b0;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    baud_end = (baud_q == C_BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (en && !fifo_empty) begin
          state_d = S_POP;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_POP: state_d = S_LOAD;

      S_LOAD: begin
        shift_d = fifo_rdata;
        par_d   = C_PAR_ODD ? ~(^fifo_rdata) : ^fifo_rdata;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b0;
        state_d = S_START;
      end

      S_START: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == C_DATA_LAST) begin
            bit_d = '0;
            if (C_PAR_EN) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
            tx_d  = shift_d[0];
          end
        end
      end

      S_PARITY: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == C_STOP_LAST) begin
            bit_d = '0;
            cnt_d = cnt_q + 8'd1;
            // Back-to-back: skip IDLE so the gap is only POP + LOAD.
            if (en && !fifo_empty) begin
              state_d = S_POP;
              rd_d    = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign fifo_rd   = rd_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign frame_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_drain.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_tx_drain
// Brief   : Self-checking bench: FIFO model, frame decoder and directed tables.
// Revision: 1.0  initial release
// ============================================================================
module tb_fifo_tx_drain;

  localparam int DW  = 3;
  localparam int CPB = 4;
  localparam int FL  = (1 + DW + 1) * CPB;

  logic          clk = 1'b0;
  logic          rst, en, fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd, tx, busy;
  logic [7:0]    frame_cnt;

  logic          en_p, empty_p;
  logic [DW-1:0] rdata_p;
  logic          rd_e, tx_e, busy_e, rd_o, tx_o, busy_o;
  logic [7:0]    cnt_e, cnt_o;

  always #5 clk = ~clk;

  fifo_tx_drain #(.DATO_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .frame_cnt(frame_cnt));

  fifo_tx_drain #(.DATO_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .en(en_p), .fifo_empty(empty_p), .fifo_rdata(rdata_p),
    .fifo_rd(rd_e), .tx(tx_e), .busy(busy_e), .frame_cnt(cnt_e));

  fifo_tx_drain #(.DATO_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .en(en_p), .fifo_empty(empty_p), .fifo_rdata(rdata_p),
    .fifo_rd(rd_o), .tx(tx_o), .busy(busy_o), .frame_cnt(cnt_o));

  int total = 0;
  int bad   = 0;

  // FIFO contents, words popped but not yet seen on the line, frame decoder
  logic [DW-1:0] q[$];
  logic [DW-1:0] expq[$];
  int            mon_cnt = -1;
  logic [DW-1:0] mon_word;
  logic          mon_err;
  int            frames  = 0;
  logic          cnt_chk = 1'b0;
  logic          rand_push = 1'b0;
  logic          p_rst, p_en, p_empty, p_rd;

  logic txh[0:50];
  logic rdh[0:50];

  typedef struct { logic [DW-1:0] data; logic [4:0] bits; } vec_t;
  typedef struct { logic [DW-1:0] data; logic pe; logic po; } pvec_t;
  vec_t  vt[6];
  pvec_t pt[3];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Line level at cycle k of a frame carrying word w (no parity, 1 stop bit)
  function automatic logic exp_level(input logic [DW-1:0] w, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    return 1'b1;
  endfunction

  task automatic tick();
    p_rst   = rst;
    p_en    = en;
    p_empty = fifo_empty;
    p_rd    = fifo_rd;
    @(posedge clk);
    #1;
    if (p_rst) begin
      mon_cnt = -1;
      expq.delete();
      frames  = 0;
      cnt_chk = 1'b0;
    end else begin
      if (fifo_rd === 1'b1) begin
        check("rd_legal", {p_en, p_empty, p_rd}, 3'b100);
        if (q.size() == 0) begin
          check("pop_nonempty", 0, 1);
          fifo_rdata = DW'($urandom);
        end else begin
          fifo_rdata = q.pop_front();
        end
        expq.push_back(fifo_rdata);
      end
      if (cnt_chk) begin
        check("frame_cnt", frame_cnt, frames % 256);
        cnt_chk = 1'b0;
      end
      if (mon_cnt < 0 && tx === 1'b0) begin
        if (expq.size() == 0) check("start_has_word", 0, 1);
        else begin
          mon_word = expq.pop_front();
          mon_cnt  = 0;
          mon_err  = 1'b0;
        end
      end
      if (mon_cnt >= 0) begin
        if (tx !== exp_level(mon_word, mon_cnt)) mon_err = 1'b1;
        if (busy !== 1'b1) mon_err = 1'b1;
        if (mon_cnt == FL - 1) begin
          check("frame_bits", mon_err, 0);
          frames++;
          cnt_chk = 1'b1;
          mon_cnt = -1;
        end else begin
          mon_cnt++;
        end
      end
    end
    if (rand_push && $urandom_range(0, 99) < 3) q.push_back(DW'($urandom));
    fifo_empty = (q.size() == 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   c0, nrd, err, ee, eo, lim, b;
    logic found, we, wo;

    vt[0] = '{3'b101, 5'b11010};
    vt[1] = '{3'b000, 5'b10000};
    vt[2] = '{3'b111, 5'b11110};
    vt[3] = '{3'b011, 5'b10110};
    vt[4] = '{3'b110, 5'b11100};
    vt[5] = '{3'b100, 5'b11000};
    pt[0] = '{3'b111, 1'b1, 1'b0};
    pt[1] = '{3'b110, 1'b0, 1'b1};
    pt[2] = '{3'b000, 1'b0, 1'b1};

    // Reset, including rst overriding a pop request
    rst = 1'b1; en = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0;
    en_p = 1'b0; empty_p = 1'b1; rdata_p = '0;
    tick();
    q.push_back(3'b111); fifo_empty = 1'b0; en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rd", fifo_rd, 0);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_par_tx", {tx_e, tx_o}, 2'b11);
    q.delete(); fifo_empty = 1'b1; en = 1'b0;
    err = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0) err++;
    end
    check("idle_hold", err, 0);

    // Parity frames on the even and odd instances
    for (int t = 0; t < 3; t++) begin
      ee = 0; eo = 0;
      empty_p = 1'b0; en_p = 1'b1;
      tick();
      check("par_rd_even", rd_e, 1);
      check("par_rd_odd", rd_o, 1);
      empty_p = 1'b1; en_p = 1'b0; rdata_p = pt[t].data;
      for (int k = 2; k <= 27; k++) begin
        tick();
        we = 1'b1; wo = 1'b1;
        if (k >= 3 && k <= 26) begin
          b = (k - 3) / CPB;
          if (b == 0) begin we = 1'b0; wo = 1'b0; end
          else if (b <= DW) begin we = pt[t].data[b-1]; wo = we; end
          else if (b == DW + 1) begin we = pt[t].pe; wo = pt[t].po; end
        end
        if (tx_e !== we) ee++;
        if (tx_o !== wo) eo++;
        if (busy_e !== (k <= 26)) ee++;
        if (busy_o !== (k <= 26)) eo++;
        if (rd_e !== 1'b0 || rd_o !== 1'b0) begin ee++; eo++; end
      end
      check("par_even_frame", ee, 0);
      check("par_odd_frame", eo, 0);
      check("par_cnt", cnt_o, t + 1);
    end

    // Table: single words with defaults
    for (int t = 0; t < 6; t++) begin
      c0 = frame_cnt;
      q.push_back(vt[t].data); fifo_empty = 1'b0; en = 1'b1;
      tick();
      check("single_rd_n1", fifo_rd, 1);
      check("single_busy_n1", busy, 1);
      tick();
      check("single_rd_n2", fifo_rd, 0);
      check("single_tx_n2", tx, 1);
      err = 0;
      for (int i = 0; i < FL; i++) begin
        tick();
        if (tx !== vt[t].bits[i / CPB]) err++;
      end
      check("single_tx_pattern", err, 0);
      tick();
      check("single_busy_end", busy, 0);
      check("single_cnt", frame_cnt, (c0 + 1) % 256);
      tick(); tick();
    end

    // Back-to-back frames
    c0 = frame_cnt;
    q.push_back(3'b011); q.push_back(3'b110); fifo_empty = 1'b0; en = 1'b1;
    nrd = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      txh[k] = tx; rdh[k] = fifo_rd; nrd += int'(fifo_rd);
    end
    check("b2b_rd_count", nrd, 2);
    check("b2b_rd2_pos", rdh[23], 1);
    check("b2b_gap", {txh[22], txh[23], txh[24], txh[25]}, 4'b1110);
    check("b2b_cnt", frame_cnt, (c0 + 2) % 256);

    // Random pushes with en toggling, then drain
    rand_push = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      tick();
    end
    rand_push = 1'b0; en = 1'b1;
    lim = 0;
    while ((q.size() > 0 || expq.size() > 0 || mon_cnt >= 0) && lim < 20000) begin
      tick(); lim++;
    end
    check("rand_drain_in_time", int'(lim < 20000), 1);
    tick(); tick();
    check("rand_all_sent", q.size() + expq.size(), 0);
    check("rand_cnt", frame_cnt, frames % 256);

    // en dropped mid-frame, then reset during START of the next frame
    c0 = frame_cnt;
    q.push_back(3'b001); q.push_back(3'b010); fifo_empty = 1'b0; en = 1'b1;
    tick();
    check("edrop_rd", fifo_rd, 1);
    for (int k = 2; k <= 9; k++) tick();
    en = 1'b0;
    nrd = 0;
    for (int k = 0; k < 40; k++) begin
      tick(); nrd += int'(fifo_rd);
    end
    check("edrop_no_pop", nrd, 0);
    check("edrop_cnt", frame_cnt, (c0 + 1) % 256);
    check("edrop_left", q.size(), 1);
    en = 1'b1; found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (tx === 1'b0) found = 1'b1;
    end
    check("abort_start_seen", found, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_rd", fifo_rd, 0);
    check("abort_cnt", frame_cnt, 0);
    nrd = 0; err = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      nrd += int'(fifo_rd);
      if (tx !== 1'b1) err++;
    end
    check("abort_no_reread", nrd, 0);
    check("abort_idle_tx", err, 0);

    // frame_cnt wrap over 256 back-to-back frames
    for (int k = 0; k < 256; k++) q.push_back(DW'($urandom));
    fifo_empty = 1'b0; en = 1'b1;
    lim = 0;
    while (!(frames >= 256 && mon_cnt < 0) && lim < 7000) begin
      tick(); lim++;
    end
    check("wrap_in_time", int'(lim < 7000), 1);
    tick();
    check("wrap_frames", frames, 256);
    check("wrap_cnt", frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
